// File: rtl/lcd_instruction_tx.sv
// Sends one 10-bit LCD word {RS, RW, D7..D0} to the Spartan-3E character LCD as two
// framed nibbles (upper first), then waits long enough for the LCD to finish the command.
module lcd_instruction_tx #(
   parameter int T_SETUP      = 2,
   parameter int T_PULSE      = 12,
   parameter int T_HOLD       = 1,
   parameter int T_GAP        = 50,
   parameter int T_WAIT_SHORT = 2000,
   parameter int T_WAIT_LONG  = 82000,
   parameter int CNT_W        = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       next_instruction,
   input  logic [9:0] db,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_E,
   output logic [3:0] SF_D,
   output logic       busy,
   output logic       done
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_UP_SETUP,
      S_UP_PULSE,
      S_UP_HOLD,
      S_GAP,
      S_LO_SETUP,
      S_LO_PULSE,
      S_LO_HOLD,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_last;
   logic             at_end, accept;
   logic             rs_q, rs_nx, long_q, long_nx;
   logic [7:0]       data_q, data_nx;
   logic [3:0]       sf_d_nx;
   logic             lcd_rs_nx, lcd_e_nx, busy_nx, done_nx;
   logic             unused_rw;

   // Reads are not supported, so the RW bit of the request has nowhere to go.
   assign unused_rw = db[8];
   assign LCD_RW    = 1'b0;

   always_comb begin
      cnt_last = '0;
      case (state)
         S_UP_SETUP, S_LO_SETUP: cnt_last = CNT_W'(T_SETUP - 1);
         S_UP_PULSE, S_LO_PULSE: cnt_last = CNT_W'(T_PULSE - 1);
         S_UP_HOLD,  S_LO_HOLD:  cnt_last = CNT_W'(T_HOLD - 1);
         S_GAP:                  cnt_last = CNT_W'(T_GAP - 1);
         S_WAIT:                 cnt_last = long_q ? CNT_W'(T_WAIT_LONG - 1)
                                                   : CNT_W'(T_WAIT_SHORT - 1);
         default:                cnt_last = '0;
      endcase
   end

   assign at_end = (cnt == cnt_last);

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      data_nx    = data_q;
      rs_nx      = rs_q;
      long_nx    = long_q;
      case (state)
         S_IDLE:     if (next_instruction) begin
                        state_next = S_UP_SETUP;
                        accept     = 1'b1;
                     end
         S_UP_SETUP: if (at_end) state_next = S_UP_PULSE;
         S_UP_PULSE: if (at_end) state_next = S_UP_HOLD;
         S_UP_HOLD:  if (at_end) state_next = S_GAP;
         S_GAP:      if (at_end) state_next = S_LO_SETUP;
         S_LO_SETUP: if (at_end) state_next = S_LO_PULSE;
         S_LO_PULSE: if (at_end) state_next = S_LO_HOLD;
         S_LO_HOLD:  if (at_end) state_next = S_WAIT;
         S_WAIT:     if (at_end) state_next = S_DONE;
         S_DONE:     state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase

      // Clear Display (0x01) and Return Home (0x02/0x03) need the long settle time.
      if (accept) begin
         data_nx = db[7:0];
         rs_nx   = db[9];
         long_nx = !db[9] && (db[7:2] == 6'd0) && (db[1:0] != 2'd0);
      end

      sf_d_nx   = SF_D;
      lcd_rs_nx = LCD_RS;
      lcd_e_nx  = 1'b0;
      busy_nx   = (state_next != S_IDLE);
      done_nx   = (state_next == S_DONE);
      case (state_next)
         S_UP_SETUP, S_UP_HOLD, S_GAP: begin
            sf_d_nx   = data_nx[7:4];
            lcd_rs_nx = rs_nx;
         end
         S_UP_PULSE: begin
            sf_d_nx   = data_nx[7:4];
            lcd_rs_nx = rs_nx;
            lcd_e_nx  = 1'b1;
         end
         S_LO_SETUP, S_LO_HOLD, S_WAIT: begin
            sf_d_nx   = data_nx[3:0];
            lcd_rs_nx = rs_nx;
         end
         S_LO_PULSE: begin
            sf_d_nx   = data_nx[3:0];
            lcd_rs_nx = rs_nx;
            lcd_e_nx  = 1'b1;
         end
         default: ;
      endcase
   end

   // Outputs are registered from the next-state decode so they change with the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         data_q <= '0;
         rs_q   <= 1'b0;
         long_q <= 1'b0;
         SF_D   <= 4'h0;
         LCD_RS <= 1'b0;
         LCD_E  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= (state_next != state || state == S_IDLE) ? '0 : cnt + CNT_W'(1);
         data_q <= data_nx;
         rs_q   <= rs_nx;
         long_q <= long_nx;
         SF_D   <= sf_d_nx;
         LCD_RS <= lcd_rs_nx;
         LCD_E  <= lcd_e_nx;
         busy   <= busy_nx;
         done   <= done_nx;
      end
   end

endmodule

// File: tb/tb_lcd_instruction_tx.sv
// Directed bench for lcd_instruction_tx: instance A uses default framing with a shortened
// long wait, instance B uses a compact reparametrisation; both share the same stimulus.
module tb_lcd_instruction_tx;

   localparam int TS  = 2;
   localparam int TP  = 12;
   localparam int TH  = 1;
   localparam int TG  = 50;
   localparam int TWS = 2000;
   localparam int TWL = 3000;
   localparam int N   = 4300;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       next_instruction = 1'b0;
   logic [9:0] db = 10'h000;

   logic       a_rs, a_rw, a_e, a_busy, a_done;
   logic [3:0] a_sfd;
   logic       b_rs, b_rw, b_e, b_busy, b_done;
   logic [3:0] b_sfd;

   logic [3:0] a_sfd_t [0:N];
   logic       a_e_t [0:N], a_rs_t [0:N], a_rw_t [0:N], a_busy_t [0:N], a_done_t [0:N];
   logic [3:0] b_sfd_t [0:N];
   logic       b_e_t [0:N], b_rs_t [0:N], b_rw_t [0:N], b_busy_t [0:N], b_done_t [0:N];

   int check_count = 0;
   int pass_count  = 0;

   lcd_instruction_tx #(
      .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG),
      .T_WAIT_SHORT(TWS), .T_WAIT_LONG(TWL), .CNT_W(17)
   ) dut_a (
      .clk(clk), .reset(reset), .next_instruction(next_instruction), .db(db),
      .LCD_RS(a_rs), .LCD_RW(a_rw), .LCD_E(a_e), .SF_D(a_sfd),
      .busy(a_busy), .done(a_done)
   );

   lcd_instruction_tx #(
      .T_SETUP(1), .T_PULSE(3), .T_HOLD(1), .T_GAP(2),
      .T_WAIT_SHORT(5), .T_WAIT_LONG(9), .CNT_W(8)
   ) dut_b (
      .clk(clk), .reset(reset), .next_instruction(next_instruction), .db(db),
      .LCD_RS(b_rs), .LCD_RW(b_rw), .LCD_E(b_e), .SF_D(b_sfd),
      .busy(b_busy), .done(b_done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
   endtask

   // Presents a word for exactly one accept edge; returns #1 into cycle 1 of the transfer.
   task automatic applyStimulus(input logic [9:0] word);
      db = word;
      next_instruction = 1'b1;
      @(posedge clk);
      #1;
      next_instruction = 1'b0;
   endtask

   task automatic captureTrace(input int n, input int inject_at, input logic [9:0] inject_word,
                               input int release_at);
      for (int c = 1; c <= n; c++) begin
         if (c == inject_at) begin
            db = inject_word;
            next_instruction = 1'b1;
         end else if (c == inject_at + 1) begin
            next_instruction = 1'b0;
         end
         if (c == release_at) next_instruction = 1'b0;
         a_sfd_t[c] = a_sfd; a_e_t[c] = a_e; a_rs_t[c] = a_rs; a_rw_t[c] = a_rw;
         a_busy_t[c] = a_busy; a_done_t[c] = a_done;
         b_sfd_t[c] = b_sfd; b_e_t[c] = b_e; b_rs_t[c] = b_rs; b_rw_t[c] = b_rw;
         b_busy_t[c] = b_busy; b_done_t[c] = b_done;
         @(posedge clk);
         #1;
      end
   endtask

   // Compares a captured trace against the per-cycle timeline of one instruction.
   task automatic checkTrace(input string tag, input bit use_b, input logic [9:0] word,
                             input int ts, input int tp, input int th, input int tg,
                             input int tw, input int n);
      int p1, h1, s2, p2, h2, d;
      int e_err, sfd_err, rs_err, rw_err, busy_err, done_cnt, first_done;
      logic e_o, rs_o, rw_o, busy_o, done_o, exp_e;
      logic [3:0] sfd_o, exp_sfd;
      p1 = 1 + ts;
      h1 = p1 + tp;
      s2 = h1 + th + tg;
      p2 = s2 + ts;
      h2 = p2 + tp;
      d  = h2 + th + tw;
      e_err = 0; sfd_err = 0; rs_err = 0; rw_err = 0; busy_err = 0;
      done_cnt = 0; first_done = 0;
      for (int c = 1; c <= n; c++) begin
         if (use_b) begin
            e_o = b_e_t[c]; rs_o = b_rs_t[c]; rw_o = b_rw_t[c];
            busy_o = b_busy_t[c]; done_o = b_done_t[c]; sfd_o = b_sfd_t[c];
         end else begin
            e_o = a_e_t[c]; rs_o = a_rs_t[c]; rw_o = a_rw_t[c];
            busy_o = a_busy_t[c]; done_o = a_done_t[c]; sfd_o = a_sfd_t[c];
         end
         exp_e   = (c >= p1 && c < h1) || (c >= p2 && c < h2);
         exp_sfd = (c < s2) ? word[7:4] : word[3:0];
         if (e_o !== exp_e) e_err++;
         if (sfd_o !== exp_sfd) sfd_err++;
         if (c < d && rs_o !== word[9]) rs_err++;
         if (rw_o !== 1'b0) rw_err++;
         if (busy_o !== (c <= d)) busy_err++;
         if (done_o === 1'b1) begin
            done_cnt++;
            if (first_done == 0) first_done = c;
         end
      end
      checkOutput({tag, "/e_bad_cycles"}, e_err, 0);
      checkOutput({tag, "/sfd_bad_cycles"}, sfd_err, 0);
      checkOutput({tag, "/rs_bad_cycles"}, rs_err, 0);
      checkOutput({tag, "/rw_bad_cycles"}, rw_err, 0);
      checkOutput({tag, "/busy_bad_cycles"}, busy_err, 0);
      checkOutput({tag, "/done_cycle"}, first_done, d);
      checkOutput({tag, "/done_count"}, done_cnt, 1);
   endtask

   initial begin
      int q[$];
      int done_seen, busy_seen, first, second;

      // Power-on reset.
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst/LCD_E", a_e, 0);
      checkOutput("rst/SF_D", a_sfd, 0);
      checkOutput("rst/LCD_RS", a_rs, 0);
      checkOutput("rst/LCD_RW", a_rw, 0);
      checkOutput("rst/busy", a_busy, 0);
      checkOutput("rst/done", a_done, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Data write 'A' then the wait-select corner cases.
      applyStimulus(10'h241); captureTrace(2086, -1, 10'h000, -1);
      checkTrace("w241", 1'b0, 10'h241, TS, TP, TH, TG, TWS, 2086);
      applyStimulus(10'h001); captureTrace(3086, -1, 10'h000, -1);
      checkTrace("w001", 1'b0, 10'h001, TS, TP, TH, TG, TWL, 3086);
      applyStimulus(10'h003); captureTrace(3086, -1, 10'h000, -1);
      checkTrace("w003", 1'b0, 10'h003, TS, TP, TH, TG, TWL, 3086);
      applyStimulus(10'h006); captureTrace(2086, -1, 10'h000, -1);
      checkTrace("w006", 1'b0, 10'h006, TS, TP, TH, TG, TWS, 2086);
      applyStimulus(10'h201); captureTrace(2086, -1, 10'h000, -1);
      checkTrace("w201", 1'b0, 10'h201, TS, TP, TH, TG, TWS, 2086);
      applyStimulus(10'h000); captureTrace(2086, -1, 10'h000, -1);
      checkTrace("w000", 1'b0, 10'h000, TS, TP, TH, TG, TWS, 2086);

      // A request at cycle 500 of a transfer must be ignored.
      applyStimulus(10'h028); captureTrace(2086, 500, 10'h0FF, -1);
      checkTrace("busyreq", 1'b0, 10'h028, TS, TP, TH, TG, TWS, 2086);

      // Held request: re-accepted in the first IDLE cycle after DONE.
      db = 10'h028;
      next_instruction = 1'b1;
      @(posedge clk);
      #1;
      captureTrace(4170, -1, 10'h000, 3000);
      checkTrace("b2b1", 1'b0, 10'h028, TS, TP, TH, TG, TWS, 2081);
      q.delete();
      for (int c = 1; c <= 4170; c++) if (a_done_t[c] === 1'b1) q.push_back(c);
      first  = (q.size() > 0) ? q[0] : -1;
      second = (q.size() > 1) ? q[1] : -1;
      checkOutput("b2b/done_count", q.size(), 2);
      checkOutput("b2b/first_done", first, 2081);
      checkOutput("b2b/spacing", second - first, 2082);
      checkOutput("b2b/busy_idle_cycle", a_busy_t[2082], 0);
      checkOutput("b2b/busy_reaccept", a_busy_t[2083], 1);

      // Reset held low for 3 cycles in the middle of an E pulse.
      applyStimulus(10'h241);
      captureTrace(4, -1, 10'h000, -1);
      checkOutput("midrst/e_before", a_e, 1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midrst/LCD_E", a_e, 0);
      checkOutput("midrst/SF_D", a_sfd, 0);
      checkOutput("midrst/LCD_RS", a_rs, 0);
      checkOutput("midrst/busy", a_busy, 0);
      checkOutput("midrst/done", a_done, 0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      done_seen = 0;
      busy_seen = 0;
      for (int c = 0; c < 4000; c++) begin
         if (a_done === 1'b1) done_seen++;
         if (a_busy === 1'b1) busy_seen++;
         @(posedge clk);
         #1;
      end
      checkOutput("midrst/no_done", done_seen, 0);
      checkOutput("midrst/no_busy", busy_seen, 0);

      // Reparametrised instance: 3-cycle pulses, done at cycle 18.
      applyStimulus(10'h241); captureTrace(2086, -1, 10'h000, -1);
      checkTrace("reparam", 1'b1, 10'h241, 1, 3, 1, 2, 5, 30);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/lcd_instruction_tx.md
Name: lcd_instruction_tx

Overview:
- Parametrised successor to the fixed-timing LCD instruction sender for the Spartan-3E character LCD (4-bit data interface).
- Accepts one 10-bit LCD word {RS, RW, D7..D0} per request and sends it as two nibbles, upper nibble first.
- Each nibble is framed by configurable setup, enable-pulse and hold times, followed by a configurable post-instruction wait.
- Selects a long wait automatically for Clear Display and Return Home.
- Sits between the LCD init/display sequencer (upstream, drives next_instruction/db) and the SF_D/LCD_* pins.

Parameters:
- T_SETUP, 2, cycles SF_D/RS stable before LCD_E rises (40 ns at 50 MHz)
- T_PULSE, 12, cycles LCD_E high per nibble (240 ns)
- T_HOLD, 1, cycles SF_D/RS held after LCD_E falls
- T_GAP, 50, cycles between upper-nibble hold end and lower-nibble setup start (1 us)
- T_WAIT_SHORT, 2000, post-instruction wait, normal commands and data writes (40 us)
- T_WAIT_LONG, 82000, post-instruction wait, Clear/Home (1.64 ms)
- CNT_W, 17, counter width; must satisfy 2^CNT_W > every T_* value
- All T_* values must be >= 1.

Ports:
- clk  in  1  system clock, 50 MHz nominal
- reset  in  1  synchronous, active-low; sampled only on rising clk
- next_instruction  in  1  request strobe; accepted only when busy=0
- db  in  10  {RS=db[9], RW=db[8], D7..D0=db[7:0]}; sampled in the accept cycle
- LCD_RS  out  1  register select to LCD
- LCD_RW  out  1  read/write to LCD; always 0
- LCD_E  out  1  LCD enable strobe
- SF_D  out  4  LCD data nibble (SF_D[3:0] = DB7..DB4)
- busy  out  1  high from the cycle after accept until return to IDLE
- done  out  1  one-cycle pulse when the post-instruction wait completes

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE and the counter clears.
  - LCD_RS=0, LCD_RW=0, LCD_E=0, SF_D=4'h0, busy=0, done=0.
  - Applies mid-transfer too: outputs reach reset values on the next edge, no done pulse, latched db discarded.
- All outputs are registered. The counter restarts at 0 on every state entry. A state with duration T occupies exactly T cycles.
- FSM: IDLE -> UP_SETUP(T_SETUP) -> UP_PULSE(T_PULSE) -> UP_HOLD(T_HOLD) -> GAP(T_GAP) -> LO_SETUP(T_SETUP) -> LO_PULSE(T_PULSE) -> LO_HOLD(T_HOLD) -> WAIT(Tw) -> DONE(1) -> IDLE.
- Accept:
  - In IDLE, next_instruction=1 at an edge latches db and enters UP_SETUP.
  - Requests are ignored in every other state, including DONE.
  - A held-high next_instruction is re-accepted in the first IDLE cycle after DONE.
- Output values by state:
  - UP_* and GAP: SF_D = latched D7..D4.
  - LO_* and WAIT: SF_D = latched D3..D0.
  - DONE and IDLE: SF_D holds its last value until the next accept.
  - LCD_RS = latched RS from UP_SETUP through WAIT.
  - LCD_E=1 only in UP_PULSE and LO_PULSE: exactly T_PULSE consecutive cycles each, two pulses per instruction.
- LCD_RW held 0. db[8] is latched but ignored; reads are not supported.
- Wait select:
  - Tw = T_WAIT_LONG iff RS=0 and D7..D2=0 and D1..D0!=0 (0x01 Clear, 0x02/0x03 Home).
  - Otherwise Tw = T_WAIT_SHORT, including db=10'h000.
- Latency: accept at edge 0 -> done=1 in cycle 1+2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP+Tw. Defaults give 2081 (short) and 82081 (long).
- busy=1 from UP_SETUP through DONE inclusive. done and busy=1 coincide in the DONE cycle; busy=0 the cycle after.
- Changes on db while busy have no effect.

Test Plan:
- Reset: hold reset=0 for 3 cycles during a transfer -> next edge LCD_E=0, SF_D=0, LCD_RS=0, busy=0; no done pulse for 100000 cycles.
- Data write db=10'h241 ('A', RS=1):
  - SF_D=4'h4 around the first E pulse, 4'h1 around the second; LCD_RS=1, LCD_RW=0.
  - Each E pulse is 12 cycles; 2 setup and 1 hold cycles around each pulse; 50 cycles between pulses' framing.
  - done at cycle 2081.
- Clear db=10'h001 -> done at cycle 82081. db=10'h003 -> long. db=10'h006 -> short (2081). db=10'h201 (RS=1) -> short.
- Request while busy: pulse next_instruction with db=10'h0FF at cycle 500 of a transfer -> ignored; SF_D never shows 4'hF; only one done.
- Back-to-back: next_instruction held 1 with db=10'h028 -> second accept in the first IDLE cycle after DONE; done pulses spaced exactly 2082 cycles apart.
- Reparametrisation (T_SETUP=1, T_PULSE=3, T_HOLD=1, T_GAP=2, T_WAIT_SHORT=5) -> E pulses 3 cycles wide; done at cycle 1+10+2+5=18.
